led_pattern_gen: RTL

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pattern_gen.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_gen
// Purpose  : Prescaled LED pattern generator (up, down, bounce, Gray count).
//            Optional manual step input enabled by macro LED_PATTERN_STEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter int LED_W      = 10,
    parameter int PRESCALE_W = 24
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic                  run,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] period,
    input  logic                  step,
    output logic [LED_W-1:0]      leds,
    output logic                  tick,
    output logic                  dir
);

    localparam logic [1:0] c_mode_up     = 2'b00;
    localparam logic [1:0] c_mode_down   = 2'b01;
    localparam logic [1:0] c_mode_bounce = 2'b10;
    localparam logic [1:0] c_mode_gray   = 2'b11;

    localparam logic [LED_W-1:0]      c_led_one = LED_W'(1);
    localparam logic [PRESCALE_W-1:0] c_pre_one = PRESCALE_W'(1);

    logic [1:0]            mode_q,   mode_d;
    logic [PRESCALE_W-1:0] pcount_q, pcount_d;
    logic [LED_W-1:0]      leds_q,   leds_d;
    logic [LED_W-1:0]      b_q,      b_d;
    logic                  tick_q,   tick_d;
    logic                  dir_q,    dir_d;

    logic                  auto_adv;
    logic                  step_adv;
    logic                  adv;
    logic [LED_W-1:0]      b_next;

`ifdef LED_PATTERN_STEP_EN
    logic step_meta_q;
    logic step_sync_q;
    logic step_prev_q;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            step_meta_q <= 1'b0;
            step_sync_q <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            step_meta_q <= step;
            step_sync_q <= step_meta_q;
            step_prev_q <= step_sync_q;
        end
    end

    // Manual steps only count while the prescaler is stopped.
    assign step_adv = step_sync_q & ~step_prev_q & ~run;
`else
    logic unused_step;
    assign unused_step = step;
    assign step_adv    = 1'b0;
`endif

    assign auto_adv = run & (pcount_q >= period);
    assign adv      = auto_adv | step_adv;

    always_comb begin
        mode_d   = mode_q;
        pcount_d = pcount_q;
        leds_d   = leds_q;
        b_d      = b_q;
        tick_d   = 1'b0;
        dir_d    = dir_q;
        b_next   = b_q + c_led_one;

        if (mode != mode_q) begin
            // A mode switch restarts the pattern and beats any pending advance.
            mode_d   = mode;
            pcount_d = '0;
            dir_d    = 1'b0;
            b_d      = '0;
            case (mode)
                c_mode_down:   leds_d = '1;
                c_mode_bounce: leds_d = c_led_one;
                default:       leds_d = '0;
            endcase
        end else begin
            if (run) begin
                pcount_d = auto_adv ? '0 : pcount_q + c_pre_one;
            end
            if (adv) begin
                tick_d = 1'b1;
                case (mode_q)
                    c_mode_up:   leds_d = leds_q + c_led_one;
                    c_mode_down: leds_d = leds_q - c_led_one;
                    c_mode_bounce: begin
                        if (!dir_q) begin
                            if (leds_q[LED_W-1]) begin
                                dir_d  = 1'b1;
                                leds_d = leds_q >> 1;
                            end else begin
                                leds_d = leds_q << 1;
                            end
                        end else begin
                            if (leds_q[0]) begin
                                dir_d  = 1'b0;
                                leds_d = leds_q << 1;
                            end else begin
                                leds_d = leds_q >> 1;
                            end
                        end
                    end
                    c_mode_gray: begin
                        b_d    = b_next;
                        leds_d = b_next ^ (b_next >> 1);
                    end
                    default: leds_d = leds_q;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            mode_q   <= c_mode_up;
            pcount_q <= '0;
            leds_q   <= '0;
            b_q      <= '0;
            tick_q   <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            pcount_q <= pcount_d;
            leds_q   <= leds_d;
            b_q      <= b_d;
            tick_q   <= tick_d;
            dir_q    <= dir_d;
        end
    end

    assign leds = leds_q;
    assign tick = tick_q;
    assign dir  = dir_q;

endmodule
`default_nettype wire
